// File: rtl/digital_synthesizer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : digital_synthesizer_pkg
// Brief   : Signal-type codes and pulse-sequencer state encoding shared with
//           the output register stage.
// Rev     : 1.0  initial release
// ============================================================================
package digital_synthesizer_pkg;

    typedef enum logic [1:0] {
        SIG_NONE  = 2'd0,
        SIG_LFM   = 2'd1,
        SIG_PSK   = 2'd2,
        SIG_NOISE = 2'd3
    } sig_type_t;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_RUN   = 3'd2;
    localparam logic [2:0] c_ST_STOP  = 3'd3;
    localparam logic [2:0] c_ST_DRAIN = 3'd4;
    localparam logic [2:0] c_ST_GUARD = 3'd5;

    // Grant bit order is {NOISE, PSK, LFM}.
    function automatic sig_type_t onehot_to_type(input logic [2:0] oh);
        sig_type_t t;
        case (oh)
            3'b001:  t = SIG_LFM;
            3'b010:  t = SIG_PSK;
            3'b100:  t = SIG_NOISE;
            default: t = SIG_NONE;
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter3.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter3
// Brief   : Combinational 3-way round-robin arbiter; the search starts at the
//           type after the last winner.
// Rev     : 1.0  initial release
// ============================================================================
module rr_arbiter3
    import digital_synthesizer_pkg::*;
(
    input  logic [2:0] i_req,
    input  sig_type_t  i_last,
    output logic [2:0] o_grant
);

    always_comb begin
        o_grant = 3'b000;
        case (i_last)
            SIG_LFM: begin
                if      (i_req[1]) o_grant = 3'b010;
                else if (i_req[2]) o_grant = 3'b100;
                else if (i_req[0]) o_grant = 3'b001;
            end
            SIG_PSK: begin
                if      (i_req[2]) o_grant = 3'b100;
                else if (i_req[0]) o_grant = 3'b001;
                else if (i_req[1]) o_grant = 3'b010;
            end
            // NOISE last (and the reset pointer) gives LFM top priority.
            default: begin
                if      (i_req[0]) o_grant = 3'b001;
                else if (i_req[1]) o_grant = 3'b010;
                else if (i_req[2]) o_grant = 3'b100;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pulse_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pulse_sequencer
// Brief   : Grants LFM/PSK/NOISE pulse requests round-robin and sequences
//           start, run, stop, output drain and inter-pulse guard time.
// Rev     : 1.0  initial release
// ============================================================================
module pulse_sequencer
    import digital_synthesizer_pkg::*;
#(
    parameter int _LEN_WIDTH = 16,
    parameter int _GUARD     = 4,
    parameter int _DRAIN_MAX = 15
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ_LFM,
    input  logic                  REQ_PSK,
    input  logic                  REQ_NOISE,
    input  logic [_LEN_WIDTH-1:0] PULSE_LEN,
    input  logic                  OUT_READY,
    output logic                  ACK_LFM,
    output logic                  ACK_PSK,
    output logic                  ACK_NOISE,
    output logic                  SIGN_LFM_START_CALC,
    output logic                  SIGN_PSK_START_CALC,
    output logic                  SIGN_NOISE_START_CALC,
    output logic                  SIGN_LFM_STOP_CALC,
    output logic                  SIGN_PSK_STOP_CALC,
    output logic                  SIGN_NOISE_STOP_CALC,
    output logic [1:0]            ACTIVE_TYPE,
    output logic                  BUSY,
    output logic                  DRAIN_ERR
);

    localparam logic [_LEN_WIDTH-1:0] c_LEN_ONE     = {{(_LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [7:0]            c_DRAIN_LAST  = 8'(_DRAIN_MAX - 1);
    localparam logic [3:0]            c_GUARD_LAST  = 4'(_GUARD - 1);
    localparam logic [2:0]            c_AFTER_DRAIN = (_GUARD == 0) ? c_ST_IDLE : c_ST_GUARD;

    logic [2:0]            r_state;
    sig_type_t             r_type;
    sig_type_t             r_last;
    logic [_LEN_WIDTH-1:0] r_pulse_cnt;
    logic [7:0]            r_drain_cnt;
    logic [3:0]            r_guard_cnt;
    logic                  r_drain_err;

    logic [2:0]            w_req;
    logic [2:0]            w_grant;
    logic                  w_in_start;
    logic                  w_in_stop;

    assign w_req = {REQ_NOISE, REQ_PSK, REQ_LFM};

    rr_arbiter3 u_arb (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= c_ST_IDLE;
            r_type      <= SIG_NONE;
            r_last      <= SIG_NOISE;
            r_pulse_cnt <= '0;
            r_drain_cnt <= '0;
            r_guard_cnt <= '0;
            r_drain_err <= 1'b0;
        end else begin
            r_drain_err <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // Length is captured at grant so later PULSE_LEN changes cannot disturb the pulse.
                    if ((|w_req) && OUT_READY) begin
                        r_type      <= onehot_to_type(w_grant);
                        r_pulse_cnt <= (PULSE_LEN == '0) ? '0 : PULSE_LEN - c_LEN_ONE;
                        r_state     <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    r_last  <= r_type;
                    r_state <= c_ST_RUN;
                end
                c_ST_RUN: begin
                    if (r_pulse_cnt == '0) begin
                        r_state <= c_ST_STOP;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt - c_LEN_ONE;
                    end
                end
                c_ST_STOP: begin
                    r_drain_cnt <= '0;
                    r_state     <= c_ST_DRAIN;
                end
                c_ST_DRAIN: begin
                    if (OUT_READY || (r_drain_cnt == c_DRAIN_LAST)) begin
                        r_drain_err <= ~OUT_READY;
                        r_type      <= SIG_NONE;
                        r_guard_cnt <= '0;
                        r_state     <= c_AFTER_DRAIN;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 8'd1;
                    end
                end
                c_ST_GUARD: begin
                    if (r_guard_cnt == c_GUARD_LAST) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_guard_cnt <= r_guard_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_type  <= SIG_NONE;
                end
            endcase
        end
    end

    assign w_in_start = (r_state == c_ST_START);
    assign w_in_stop  = (r_state == c_ST_STOP);

    assign ACK_LFM               = w_in_start && (r_type == SIG_LFM);
    assign ACK_PSK               = w_in_start && (r_type == SIG_PSK);
    assign ACK_NOISE             = w_in_start && (r_type == SIG_NOISE);
    assign SIGN_LFM_START_CALC   = ACK_LFM;
    assign SIGN_PSK_START_CALC   = ACK_PSK;
    assign SIGN_NOISE_START_CALC = ACK_NOISE;
    assign SIGN_LFM_STOP_CALC    = w_in_stop && (r_type == SIG_LFM);
    assign SIGN_PSK_STOP_CALC    = w_in_stop && (r_type == SIG_PSK);
    assign SIGN_NOISE_STOP_CALC  = w_in_stop && (r_type == SIG_NOISE);
    assign ACTIVE_TYPE           = r_type;
    assign BUSY                  = (r_state != c_ST_IDLE);
    assign DRAIN_ERR             = r_drain_err;

endmodule
`default_nettype wire

// File: tb/tb_pulse_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pulse_sequencer
// Brief   : Self-checking bench for pulse_sequencer, timing predicted from the
//           state durations and a round-robin pick over pending requests.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pulse_sequencer;

    localparam int DMAX    = 15;
    localparam int GUARD_N = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        OUT_READY;
    logic [15:0] PULSE_LEN;
    logic [2:0]  pend;
    logic        REQ_LFM, REQ_PSK, REQ_NOISE;
    logic        ACK_LFM, ACK_PSK, ACK_NOISE;
    logic        S_LFM, S_PSK, S_NOISE, P_LFM, P_PSK, P_NOISE;
    logic [1:0]  ACTIVE_TYPE;
    logic        BUSY, DRAIN_ERR;
    logic [2:0]  st_v, sp_v, ack_v;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rr_last = 3;
    logic mon_en = 1'b0;
    int ts, tp, lat, ts_prev, n, w, len, rlow;

    assign REQ_LFM   = pend[0];
    assign REQ_PSK   = pend[1];
    assign REQ_NOISE = pend[2];
    assign st_v  = {S_NOISE, S_PSK, S_LFM};
    assign sp_v  = {P_NOISE, P_PSK, P_LFM};
    assign ack_v = {ACK_NOISE, ACK_PSK, ACK_LFM};

    pulse_sequencer #(._LEN_WIDTH(16), ._GUARD(GUARD_N), ._DRAIN_MAX(DMAX)) dut (
        .CLK                   (CLK),
        .RESET                 (RESET),
        .REQ_LFM               (REQ_LFM),
        .REQ_PSK               (REQ_PSK),
        .REQ_NOISE             (REQ_NOISE),
        .PULSE_LEN             (PULSE_LEN),
        .OUT_READY             (OUT_READY),
        .ACK_LFM               (ACK_LFM),
        .ACK_PSK               (ACK_PSK),
        .ACK_NOISE             (ACK_NOISE),
        .SIGN_LFM_START_CALC   (S_LFM),
        .SIGN_PSK_START_CALC   (S_PSK),
        .SIGN_NOISE_START_CALC (S_NOISE),
        .SIGN_LFM_STOP_CALC    (P_LFM),
        .SIGN_PSK_STOP_CALC    (P_PSK),
        .SIGN_NOISE_STOP_CALC  (P_NOISE),
        .ACTIVE_TYPE           (ACTIVE_TYPE),
        .BUSY                  (BUSY),
        .DRAIN_ERR             (DRAIN_ERR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] oh(input int t);
        if (t < 1 || t > 3) return 3'b000;
        return 3'b001 << (t - 1);
    endfunction

    // Round-robin reference: first pending type after the last one served.
    function automatic int rr_pick(input logic [2:0] p, input int last);
        int c;
        for (int k = 1; k <= 3; k++) begin
            c = ((last + k - 1) % 3) + 1;
            if (p[c-1]) return c;
        end
        return 0;
    endfunction

    // START + RUN + STOP + DRAIN + GUARD + one IDLE cycle.
    function automatic int gap(input int l, input int r);
        return 1 + ((l == 0) ? 1 : l) + 1 + ((r < DMAX) ? r + 1 : DMAX) + GUARD_N + 1;
    endfunction

    // One full pulse of type t; rlow = number of low OUT_READY samples in DRAIN.
    task automatic pulse(input int t, input int l, input int r,
                         output int t_start, output int t_stop, output int latency);
        int  k, nl;
        logic done;
        nl = (l == 0) ? 1 : l;
        k  = 0;
        do begin @(negedge CLK); k++; end while (st_v == 3'b000 && k < 64);
        latency = k;
        t_start = cyc;
        chk("start_vec", 32'(st_v), 32'(oh(t)));
        chk("ack_vec", 32'(ack_v), 32'(oh(t)));
        chk("start_type", 32'(ACTIVE_TYPE), 32'(t));
        pend[t-1] = 1'b0;
        PULSE_LEN = 16'($urandom);
        rr_last = t;
        for (int i = 0; i < nl; i++) begin
            @(negedge CLK);
            chk("run_no_stop", 32'(sp_v), 32'd0);
            chk("run_type", 32'(ACTIVE_TYPE), 32'(t));
        end
        @(negedge CLK);
        t_stop = cyc;
        chk("stop_vec", 32'(sp_v), 32'(oh(t)));
        chk("stop_type", 32'(ACTIVE_TYPE), 32'(t));
        done = 1'b0;
        for (int i = 0; i < DMAX && !done; i++) begin
            @(negedge CLK);
            chk("drain_type", 32'(ACTIVE_TYPE), 32'(t));
            chk("drain_err_low", 32'(DRAIN_ERR), 32'd0);
            done = (i == r);
            OUT_READY = done;
        end
        @(negedge CLK);
        chk("post_drain_err", 32'(DRAIN_ERR), 32'(r >= DMAX));
        chk("post_drain_type", 32'(ACTIVE_TYPE), 32'd0);
        chk("post_drain_busy", 32'(BUSY), 32'(GUARD_N > 0));
        for (int i = 1; i < GUARD_N; i++) begin
            @(negedge CLK);
            chk("guard_busy", 32'(BUSY), 32'd1);
            chk("guard_err", 32'(DRAIN_ERR), 32'd0);
        end
        @(negedge CLK);
        chk("idle_busy", 32'(BUSY), 32'd0);
        chk("idle_type", 32'(ACTIVE_TYPE), 32'd0);
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            chk("ack_equals_start", 32'(ack_v), 32'(st_v));
            chk("start_matches_type", 32'(st_v & ~oh(int'(ACTIVE_TYPE))), 32'd0);
            chk("stop_matches_type", 32'(sp_v & ~oh(int'(ACTIVE_TYPE))), 32'd0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; OUT_READY = 1'b1; pend = 3'b111; PULSE_LEN = 16'd2;
        repeat (3) @(negedge CLK);
        mon_en = 1'b1;
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_type", 32'(ACTIVE_TYPE), 32'd0);
        chk("rst_start", 32'(st_v), 32'd0);
        chk("rst_stop", 32'(sp_v), 32'd0);
        chk("rst_err", 32'(DRAIN_ERR), 32'd0);
        rr_last = 3;
        RESET = 1'b0;

        // All three requests from reset: LFM, PSK, NOISE, then LFM again.
        pulse(1, 2, 2, ts, tp, lat);
        chk("first_grant_latency", 32'(lat), 32'd1);
        ts_prev = ts; pend[0] = 1'b1; PULSE_LEN = 16'd2;
        pulse(2, 2, 2, ts, tp, lat);
        chk("rr_gap_psk", 32'(ts - ts_prev), 32'(gap(2, 2)));
        ts_prev = ts; PULSE_LEN = 16'd2;
        pulse(3, 2, 2, ts, tp, lat);
        chk("rr_gap_noise", 32'(ts - ts_prev), 32'(gap(2, 2)));
        ts_prev = ts; PULSE_LEN = 16'd2;
        pulse(1, 2, 2, ts, tp, lat);
        chk("rr_gap_lfm", 32'(ts - ts_prev), 32'(gap(2, 2)));

        pend = 3'b001; PULSE_LEN = 16'd5;
        pulse(1, 5, 0, ts, tp, lat);
        chk("lfm_len5_stop_delay", 32'(tp - ts), 32'd6);

        pend = 3'b010; PULSE_LEN = 16'd0;
        pulse(2, 0, 1, ts, tp, lat);
        chk("len0_stop_delay", 32'(tp - ts), 32'd2);

        // PSK is raised then dropped while busy; NOISE must win next.
        pend = 3'b001; PULSE_LEN = 16'd8;
        fork
            pulse(1, 8, 0, ts, tp, lat);
            begin
                repeat (3) @(negedge CLK);
                pend[1] = 1'b1;
                repeat (4) @(negedge CLK);
                pend[1] = 1'b0;
                pend[2] = 1'b1;
            end
        join
        PULSE_LEN = 16'd1;
        pulse(3, 1, 0, ts, tp, lat);

        // Drain timeout, then grants held off while OUT_READY is low.
        pend = 3'b010; PULSE_LEN = 16'd3;
        pulse(2, 3, DMAX + 5, ts, tp, lat);
        pend[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("blocked_busy", 32'(BUSY), 32'd0);
            chk("blocked_ack", 32'(ack_v), 32'd0);
        end
        OUT_READY = 1'b1; PULSE_LEN = 16'd2;
        pulse(1, 2, 0, ts, tp, lat);
        chk("unblocked_latency", 32'(lat), 32'd1);

        // Reset during RUN with PSK pending.
        pend = 3'b001; PULSE_LEN = 16'd20;
        n = 0;
        do begin @(negedge CLK); n++; end while (st_v == 3'b000 && n < 64);
        chk("pre_reset_start", 32'(st_v), 32'(oh(1)));
        pend = 3'b010;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("pending_no_ack", 32'(ack_v), 32'd0);
            chk("run_no_stop_pre_reset", 32'(sp_v), 32'd0);
        end
        RESET = 1'b1; pend = 3'b011; OUT_READY = 1'b0;
        @(negedge CLK);
        chk("mid_rst_busy", 32'(BUSY), 32'd0);
        chk("mid_rst_type", 32'(ACTIVE_TYPE), 32'd0);
        chk("mid_rst_stop", 32'(sp_v), 32'd0);
        RESET = 1'b0;
        rr_last = 3;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            chk("post_rst_ready_low_busy", 32'(BUSY), 32'd0);
            chk("post_rst_no_stop", 32'(sp_v), 32'd0);
        end
        OUT_READY = 1'b1; PULSE_LEN = 16'd3;
        pulse(1, 3, 0, ts, tp, lat);
        chk("post_rst_latency", 32'(lat), 32'd1);
        PULSE_LEN = 16'd2;
        pulse(2, 2, 1, ts, tp, lat);

        // Randomised requests, lengths and drain behaviour against the model.
        for (int it = 0; it < 10; it++) begin
            pend = pend | 3'($urandom_range(0, 7));
            if (pend == 3'b000) pend = 3'b001 << $urandom_range(0, 2);
            w    = rr_pick(pend, rr_last);
            len  = $urandom_range(0, 6);
            rlow = ($urandom_range(0, 4) == 0) ? DMAX + 1 : $urandom_range(0, 3);
            OUT_READY = 1'b1;
            PULSE_LEN = 16'(len);
            pulse(w, len, rlow, ts, tp, lat);
            chk("rand_stop_delay", 32'(tp - ts), 32'(((len == 0) ? 1 : len) + 1));
            chk("rand_latency", 32'(lat), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
